seg7_scan_decoder: RTL and testbench

Receive-side monitor for the multiplexed seven-segment display bus. Samples the active-low anode and segment lines, waits for each digit's pattern to settle, decodes the pattern back to a hex nibble, and rebuilds the displayed word. It is used for loopback self-check of the display path on board and as a scoreboard front-end in simulation. It is the inverse of the hex-to-segment encoding used by the display driver.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_pattern_decode.sv | 28 ++
 rtl/seg7_scan_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment receive path.
//   SEG_BLANK     : all-segments-off pattern (active-low, gfedcba).
//   seg_encode()  : hex nibble -> active-low gfedcba pattern, the same
//                   table the display driver uses.
//   scan_state_e  : capture FSM states of seg7_scan_decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment table.
//   pat_i    in  7  active-low segment pattern, gfedcba (bit 6 = g)
//   legal_o  out 1  pattern is one of the 16 hex codes
//   blank_o  out 1  pattern is the all-off blank code
//   nibble_o out 4  decoded hex value (0 when not legal)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    legal_o  = 1'b0;
    nibble_o = 4'h0;
    // Table codes are unique, so at most one entry can match.
    for (int k = 0; k < 16; k++) begin
      if (pat_i == seg_encode(4'(k))) begin
        legal_o  = 1'b1;
        nibble_o = 4'(k);
      end
    end
    blank_o = (pat_i == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for the multiplexed seven-segment bus. Samples the
// active-low anode/segment lines, waits for each digit's pattern to stay
// unchanged for STABLE_CYCLES samples, decodes it and rebuilds the word.
//   clk          in  1         system clock
//   rst_n        in  1         asynchronous active-low reset
//   clear        in  1         synchronous clear, beats capture
//   an           in  DIGITS    anode enables, active-low
//   a2g          in  7         segments, active-low, gfedcba
//   value        out 4*DIGITS  decoded word, nibble i = digit i
//   digit_valid  out DIGITS    digit i holds a decoded hex pattern
//   frame_valid  out 1         pulse: every digit captured since last pulse
//   bad_pattern  out 1         sticky: settled pattern matched no code
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            a2g,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  bad_pattern
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Sample stage plus a copy of the previous sample for change detection.
  logic [DIGITS-1:0]   an_q, last_an_q;
  logic [6:0]          a2g_q, last_a2g_q;

  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                capture;

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dv_q, dv_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                fv_q, fv_d;
  logic                bad_q, bad_d;

  logic [DIGITS-1:0]   sel;
  logic                selecting;
  logic                changed;
  logic                pat_legal, pat_blank;
  logic [3:0]          pat_nib;

  seg7_pattern_decode u_dec (
    .pat_i    (a2g_q),
    .legal_o  (pat_legal),
    .blank_o  (pat_blank),
    .nibble_o (pat_nib)
  );

  // A selection is exactly one low anode; sel is then one-hot.
  assign sel       = ~an_q;
  assign selecting = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
  assign changed   = ({an_q, a2g_q} != {last_an_q, last_a2g_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q       <= '1;
      a2g_q      <= SEG_BLANK;
      last_an_q  <= '1;
      last_a2g_q <= SEG_BLANK;
    end else if (clear) begin
      an_q       <= '1;
      a2g_q      <= SEG_BLANK;
      last_an_q  <= '1;
      last_a2g_q <= SEG_BLANK;
    end else begin
      an_q       <= an;
      a2g_q      <= a2g;
      last_an_q  <= an_q;
      last_a2g_q <= a2g_q;
    end
  end

  // cnt_q counts how many times the current sample has been seen in a row;
  // capture fires on the edge where that count reaches STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (selecting) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (changed || !selecting) begin
          state_d = selecting ? ST_SETTLE : ST_IDLE;
          cnt_d   = selecting ? CNT_ONE : '0;
        end else if (cnt_q >= CNT_LAST) begin
          capture = 1'b1;
          state_d = ST_HELD;
          cnt_d   = sat_inc(cnt_q);
        end else begin
          cnt_d   = sat_inc(cnt_q);
        end
      end
      ST_HELD: begin
        if (changed || !selecting) begin
          state_d = selecting ? ST_SETTLE : ST_IDLE;
          cnt_d   = selecting ? CNT_ONE : '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output update. A full seen mask produces the frame pulse and is
  // emptied in the same cycle; a capture on that cycle starts the new frame.
  always_comb begin
    value_d = value_q;
    dv_d    = dv_q;
    bad_d   = bad_q;
    fv_d    = &seen_q;
    seen_d  = (&seen_q) ? '0 : seen_q;
    if (capture) begin
      if (pat_legal) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel[i]) begin
            value_d[4*i +: 4] = pat_nib;
            dv_d[i]           = 1'b1;
            seen_d[i]         = 1'b1;
          end
        end
      end else if (pat_blank) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel[i]) begin
            dv_d[i]   = 1'b0;
            seen_d[i] = 1'b1;
          end
        end
      end else begin
        bad_d = 1'b1;
      end
    end
    if (clear) begin
      value_d = '0;
      dv_d    = '0;
      seen_d  = '0;
      fv_d    = 1'b0;
      bad_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dv_q    <= '0;
      seen_q  <= '0;
      fv_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      dv_q    <= dv_d;
      seen_q  <= seen_d;
      fv_q    <= fv_d;
      bad_q   <= bad_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = dv_q;
  assign frame_valid = fv_q;
  assign bad_pattern = bad_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  an;
  logic [6:0]  a2g;
  logic [31:0] value;
  logic [7:0]  digit_valid;
  logic        frame_valid;
  logic        bad_pattern;

  seg7_scan_decoder #(.DIGITS(8), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .an          (an),
    .a2g         (a2g),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern)
  );

  always #5 clk = ~clk;

  logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;
  int dut_frames = 0;

  // Reference model: tracks how long the sampled bus has been unchanged and
  // schedules a capture one edge after the STABLE-th identical sample.
  logic [31:0] m_value;
  logic [7:0]  m_dv, m_seen;
  logic        m_fv, m_bad;
  logic [14:0] m_prev;
  int          m_run;
  logic        m_cap;
  logic [14:0] m_cap_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int one_low(input logic [7:0] a);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < 8; i++) if (!a[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic int code_of(input logic [6:0] g);
    for (int k = 0; k < 16; k++) if (CODES[k] == g) return k;
    return -1;
  endfunction

  task automatic mdl_reset();
    m_value = '0; m_dv = '0; m_seen = '0; m_fv = 0; m_bad = 0;
    m_prev = {8'hFF, 7'h7F}; m_run = 1; m_cap = 0; m_cap_s = '0;
  endtask

  task automatic mdl_edge(input logic [7:0] a, input logic [6:0] g, input logic c);
    logic [14:0] s;
    int d, k;
    logic full;
    full = &m_seen;
    if (c) begin
      m_value = '0; m_dv = '0; m_seen = '0; m_fv = 0; m_bad = 0; m_cap = 0;
      s = {8'hFF, 7'h7F};
    end else begin
      m_fv = full;
      if (full) m_seen = '0;
      if (m_cap) begin
        d = one_low(m_cap_s[14:7]);
        k = code_of(m_cap_s[6:0]);
        if (k >= 0) begin
          m_value[4*d +: 4] = 4'(k);
          m_dv[d] = 1'b1;
          m_seen[d] = 1'b1;
        end else if (m_cap_s[6:0] == 7'h7F) begin
          m_dv[d] = 1'b0;
          m_seen[d] = 1'b1;
        end else begin
          m_bad = 1'b1;
        end
      end
      s = {a, g};
    end
    if (s == m_prev) m_run++; else m_run = 1;
    m_prev = s;
    m_cap = (one_low(s[14:7]) >= 0) && (m_run == STABLE);
    m_cap_s = s;
  endtask

  task automatic step(input logic [7:0] a, input logic [6:0] g, input logic c);
    @(negedge clk);
    an = a; a2g = g; clear = c;
    @(posedge clk);
    mdl_edge(a, g, c);
    #1;
    if (frame_valid) dut_frames++;
    chk("value", 64'(value), 64'(m_value));
    chk("digit_valid", 64'(digit_valid), 64'(m_dv));
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    chk("bad_pattern", 64'(bad_pattern), 64'(m_bad));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'hFF, 7'h7F, 1'b0);
  endtask

  task automatic show_digit(input int d, input logic [6:0] g, input int dwell);
    for (int i = 0; i < dwell; i++) step(~(8'd1 << d), g, 1'b0);
  endtask

  task automatic scan_word(input logic [31:0] w, input int dwell);
    for (int d = 0; d < 8; d++) show_digit(d, CODES[w[4*d +: 4]], dwell);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    an = 8'hFF; a2g = 7'h7F; clear = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_value", 64'(value), 64'h0);
    chk("rst_dv", 64'(digit_valid), 64'h0);
    chk("rst_fv", 64'(frame_valid), 64'h0);
    chk("rst_bad", 64'(bad_pattern), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
  endtask

  initial begin
    int f0;
    logic [31:0] w;
    logic [7:0]  ra;
    logic [6:0]  rg;
    int dw;

    an = 8'hFF; a2g = 7'h7F; clear = 1'b0; rst_n = 1'b1;
    mdl_reset();
    do_reset();
    idle(10);
    chk("idle_frames", 64'(dut_frames), 64'd0);

    // Full scan of 0x1234ABCD, dwell 6.
    f0 = dut_frames;
    scan_word(32'h1234ABCD, 6);
    idle(3);
    chk("scan_value", 64'(value), 64'h1234ABCD);
    chk("scan_dv", 64'(digit_valid), 64'hFF);
    chk("scan_frames", 64'(dut_frames - f0), 64'd1);

    // Digit 3: an 8 that does not settle, then a 9 that does.
    show_digit(3, 7'h00, 3);
    for (int j = 0; j < 5; j++) begin
      step(~8'h08, 7'h10, 1'b0);
      if (j == 3) chk("d3_early", 64'(value[15:12]), 64'hA);
      if (j == 4) chk("d3_cap", 64'(value[15:12]), 64'h9);
    end

    // Blank on digit 5 still completes the frame.
    f0 = dut_frames;
    for (int d = 0; d < 8; d++)
      show_digit(d, (d == 5) ? 7'h7F : CODES[d + 1], 6);
    idle(3);
    chk("blank_dv5", 64'(digit_valid[5]), 64'd0);
    chk("blank_bad", 64'(bad_pattern), 64'd0);
    chk("blank_frames", 64'(dut_frames - f0), 64'd1);

    // Illegal pattern on digit 2 is sticky and leaves the nibble alone.
    show_digit(2, 7'h55, 6);
    idle(8);
    chk("bad_set", 64'(bad_pattern), 64'd1);
    chk("bad_nib2", 64'(value[11:8]), 64'h3);

    // Multiple lows are idle; single low captures after STABLE samples.
    step(8'hFF, 7'h7F, 1'b1);
    for (int i = 0; i < 20; i++) step(8'b1111_0011, CODES[5], 1'b0);
    chk("multi_dv", 64'(digit_valid), 64'h0);
    chk("multi_bad", 64'(bad_pattern), 64'd0);
    show_digit(0, CODES[5], 5);
    chk("single_nib0", 64'(value[3:0]), 64'h5);
    chk("single_dv", 64'(digit_valid), 64'h01);

    // Clear on the capture edge of the frame-completing digit.
    step(8'hFF, 7'h7F, 1'b1);
    w = 32'hCAFEF00D;
    for (int d = 0; d < 7; d++) show_digit(d, CODES[w[4*d +: 4]], 6);
    f0 = dut_frames;
    for (int j = 0; j < 5; j++) step(~8'h80, CODES[4'hC], (j == 4));
    chk("clr_value", 64'(value), 64'h0);
    chk("clr_dv", 64'(digit_valid), 64'h0);
    idle(4);
    chk("clr_frames", 64'(dut_frames - f0), 64'd0);

    // Reset in the middle of a settle, then a full dwell is needed again.
    scan_word(32'h89ABCDEF, 5);
    show_digit(4, CODES[7], 2);
    do_reset();
    show_digit(4, CODES[7], 6);
    chk("post_rst_nib4", 64'(value[19:16]), 64'h7);

    // Randomized bus activity against the model.
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom_range(9))
        0:       ra = 8'hFF;
        1:       ra = 8'($urandom);
        default: ra = ~(8'd1 << $urandom_range(7));
      endcase
      case ($urandom_range(9))
        0:       rg = 7'h7F;
        1:       rg = 7'($urandom);
        default: rg = CODES[$urandom_range(15)];
      endcase
      dw = $urandom_range(1, 8);
      for (int i = 0; i < dw; i++) step(ra, rg, ($urandom_range(99) < 2));
      if (seg == 150) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
